// File: rtl/matpul_pkg.sv
// Shared definitions for the MAC datapath result path.
package matpul_pkg;

   // Width of the MAC adder-tree output
   localparam int SUM_W = 20;

   // Result writer job states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rw_state_t;

endpackage

// File: rtl/result_writer_fifo.sv
// rw_fifo: small synchronous FIFO buffering formatted sums ahead of the SRAM.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
// The head is shown combinationally from storage; level reports occupancy.
module rw_fifo #(
   parameter int W     = 20,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_r [DEPTH];
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_r;
   logic [PW:0]   cnt_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign full      = (cnt_r == (PW+1)'(DEPTH));
   assign empty     = (cnt_r == '0);
   assign level     = cnt_r;
   assign dout      = mem_r[rd_ptr_r];
   assign do_pop_s  = pop && !empty;
   assign do_push_s = push && (!full || do_pop_s);

   // Storage write; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         cnt_r    <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   cnt_r <= cnt_r + (PW+1)'(1);
            2'b01:   cnt_r <= cnt_r - (PW+1)'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

endmodule

// File: rtl/result_writer.sv
// result_writer: drains MAC result sums into the result SRAM at consecutive
// addresses, absorbing SRAM backpressure in a small FIFO and pulsing done
// once N_RESULTS sums have been accepted and every buffered one written.
// Build option: define RW_SAT_EN to clamp oversized sums to the SRAM word
// maximum instead of truncating them.
module result_writer
#(
   parameter int N_RESULTS  = 9,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 8,
   parameter int SUM_W      = matpul_pkg::SUM_W,
   parameter int OUT_W      = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              web_in,
   input  logic [SUM_W-1:0]  sum_in,
   input  logic              ram_ready,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [OUT_W-1:0]  ram_wdata,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   import matpul_pkg::*;

   localparam int CW = $clog2(N_RESULTS + 1);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0]    LAST_ACC = CW'(N_RESULTS - 1);
   localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
   localparam logic [SUM_W-1:0] OUT_MAX  = SUM_W'({OUT_W{1'b1}});

   rw_state_t         state_r;
   rw_state_t         state_nx;
   logic [CW-1:0]     acc_cnt_r;
   logic [ADDR_W-1:0] wr_cnt_r;
   logic [ADDR_W-1:0] base_r;
   logic [ADDR_W-1:0] hold_addr_r;
   logic [OUT_W-1:0]  hold_data_r;
   logic              overflow_r;
   logic              busy_r;
   logic              done_r;

   logic              push_s;
   logic              pop_s;
   logic              full_s;
   logic              empty_s;
   logic [LW-1:0]     level_s;
   logic [OUT_W-1:0]  fmt_s;
   logic [OUT_W-1:0]  head_s;
   logic [ADDR_W-1:0] live_addr_s;
   logic              start_acc_s;
   logic              accept_last_s;
   logic              last_write_s;

   // Reduce a raw sum to the SRAM word width
   function automatic logic [OUT_W-1:0] fmt_sum(input logic [SUM_W-1:0] s);
`ifdef RW_SAT_EN
      if (s > OUT_MAX) begin
         return OUT_MAX[OUT_W-1:0];
      end else begin
         return s[OUT_W-1:0];
      end
`else
      return s[OUT_W-1:0];
`endif
   endfunction

   assign fmt_s         = fmt_sum(sum_in);
   assign push_s        = (state_r == RUN) && web_in;
   assign pop_s         = !empty_s && ram_ready;
   assign start_acc_s   = (state_r == IDLE) && start;
   assign accept_last_s = push_s && (acc_cnt_r == LAST_ACC);
   assign last_write_s  = pop_s && (level_s == LVL_ONE);
   assign live_addr_s   = base_r + wr_cnt_r;

   rw_fifo #(
      .W     (OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .din   (fmt_s),
      .dout  (head_s),
      .full  (full_s),
      .empty (empty_s),
      .level (level_s)
   );

   // SRAM port: live head while data is buffered, last committed write otherwise
   assign ram_we    = !empty_s;
   assign ram_addr  = empty_s ? hold_addr_r : live_addr_s;
   assign ram_wdata = empty_s ? hold_data_r : head_s;
   assign busy      = busy_r;
   assign done      = done_r;
   assign overflow  = overflow_r;

   // Job sequencing: accept start, collect sums, drain the buffer, signal done
   always_comb begin
      state_nx = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_nx = RUN;
            else       state_nx = IDLE;
         end
         RUN: begin
            if (accept_last_s) state_nx = DRAIN;
            else               state_nx = RUN;
         end
         DRAIN: begin
            if (last_write_s) state_nx = DONE;
            else              state_nx = DRAIN;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State, counters, held SRAM values and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         acc_cnt_r   <= '0;
         wr_cnt_r    <= '0;
         base_r      <= '0;
         hold_addr_r <= '0;
         hold_data_r <= '0;
         overflow_r  <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r <= state_nx;
         busy_r  <= (state_nx == RUN) || (state_nx == DRAIN);
         done_r  <= (state_nx == DONE);
         if (start_acc_s) begin
            base_r     <= base_addr;
            acc_cnt_r  <= '0;
            wr_cnt_r   <= '0;
            overflow_r <= 1'b0;
         end else begin
            if (push_s) begin
               acc_cnt_r <= acc_cnt_r + CW'(1);
            end
            if (pop_s) begin
               wr_cnt_r <= wr_cnt_r + ADDR_W'(1);
            end
            if (push_s && full_s && !pop_s) begin
               overflow_r <= 1'b1;
            end
         end
         if (pop_s) begin
            hold_addr_r <= live_addr_s;
            hold_data_r <= head_s;
         end
      end
   end

endmodule

// File: tb/tb_result_writer.sv
// Directed bench for result_writer built with OUT_W=16 so formatting is exercised.
module tb_result_writer;

   typedef logic [19:0] sums_t [9];
   typedef logic [15:0] exps_t [9];

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  base_addr;
   logic        web_in;
   logic [19:0] sum_in;
   logic        ram_ready;
   logic        ram_we;
   logic [7:0]  ram_addr;
   logic [15:0] ram_wdata;
   logic        busy;
   logic        done;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   sums_t s;
   exps_t e;

   result_writer #(
      .N_RESULTS  (9),
      .FIFO_DEPTH (4),
      .ADDR_W     (8),
      .SUM_W      (20),
      .OUT_W      (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .web_in    (web_in),
      .sum_in    (sum_in),
      .ram_ready (ram_ready),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_job(input logic [7:0] b);
      start     = 1'b1;
      base_addr = b;
      step();
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_ovf_clear", 32'(overflow), 32'd0);
   endtask

   task automatic job_flow(input logic [7:0] b, input sums_t sv, input exps_t ev);
      logic [7:0] a;
      start_job(b);
      ram_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         web_in = 1'b1;
         sum_in = sv[i];
         step();
         a = b + 8'(i);
         chk("job_we", 32'(ram_we), 32'd1);
         chk("job_addr", 32'(ram_addr), 32'(a));
         chk("job_data", 32'(ram_wdata), 32'(ev[i]));
      end
      web_in = 1'b0;
      step();
      a = b + 8'd8;
      chk("job_done", 32'(done), 32'd1);
      chk("job_we_end", 32'(ram_we), 32'd0);
      chk("job_busy_end", 32'(busy), 32'd0);
      chk("job_hold_addr", 32'(ram_addr), 32'(a));
      chk("job_hold_data", 32'(ram_wdata), 32'(ev[8]));
      step();
      chk("job_done_pulse", 32'(done), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      base_addr = 8'h00;
      web_in    = 1'b0;
      sum_in    = 20'h0;
      ram_ready = 1'b0;
      step();
      step();
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_data", 32'(ram_wdata), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;

      // web_in outside RUN is ignored
      web_in = 1'b1;
      sum_in = 20'h5;
      step();
      web_in = 1'b0;
      chk("idle_web_we", 32'(ram_we), 32'd0);
      chk("idle_web_busy", 32'(busy), 32'd0);

      // 1: plain job, sums 1..9 from 0x10
      s = '{20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6, 20'd7, 20'd8, 20'd9};
      e = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
      job_flow(8'h10, s, e);

      // 2: backpressure fills the FIFO exactly, no overflow
      start_job(8'h20);
      ram_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         web_in = 1'b1;
         sum_in = 20'h100 + 20'(k);
         step();
         chk("bp_we", 32'(ram_we), 32'd1);
         chk("bp_head", 32'(ram_wdata), 32'h100);
         chk("bp_addr", 32'(ram_addr), 32'h20);
         chk("bp_ovf", 32'(overflow), 32'd0);
      end
      web_in    = 1'b0;
      ram_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("bp_drain_we", 32'(ram_we), 32'd1);
         chk("bp_drain_addr", 32'(ram_addr), 32'h20 + 32'(k));
         chk("bp_drain_data", 32'(ram_wdata), 32'h100 + 32'(k));
         step();
      end
      chk("bp_empty_we", 32'(ram_we), 32'd0);
      for (int j = 0; j < 5; j++) begin
         web_in = 1'b1;
         sum_in = 20'h104 + 20'(j);
         step();
         chk("bp_rest_addr", 32'(ram_addr), 32'h24 + 32'(j));
         chk("bp_rest_data", 32'(ram_wdata), 32'h104 + 32'(j));
      end
      web_in = 1'b0;
      step();
      chk("bp_done", 32'(done), 32'd1);
      chk("bp_no_ovf", 32'(overflow), 32'd0);
      step();

      // 3: fifth sum under backpressure is dropped
      start_job(8'h40);
      ram_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         web_in = 1'b1;
         sum_in = 20'h200 + 20'(k);
         step();
         chk("ovf_flag", 32'(overflow), (k == 4) ? 32'd1 : 32'd0);
         chk("ovf_head", 32'(ram_wdata), 32'h200);
      end
      web_in    = 1'b0;
      ram_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("ovf_drain_we", 32'(ram_we), 32'd1);
         chk("ovf_drain_addr", 32'(ram_addr), 32'h40 + 32'(k));
         chk("ovf_drain_data", 32'(ram_wdata), 32'h200 + 32'(k));
         step();
      end
      chk("ovf_empty_we", 32'(ram_we), 32'd0);
      chk("ovf_still_busy", 32'(busy), 32'd1);
      for (int j = 0; j < 4; j++) begin
         web_in = 1'b1;
         sum_in = 20'h205 + 20'(j);
         step();
         chk("ovf_rest_addr", 32'(ram_addr), 32'h44 + 32'(j));
         chk("ovf_rest_data", 32'(ram_wdata), 32'h205 + 32'(j));
      end
      web_in = 1'b0;
      step();
      chk("ovf_done", 32'(done), 32'd1);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      step();

      // 4: address wrap from 0xFE
      for (int i = 0; i < 9; i++) begin
         s[i] = 20'h300 + 20'(i);
         e[i] = 16'h300 + 16'(i);
      end
      job_flow(8'hFE, s, e);

      // 5: formatting of sums wider than the SRAM word
      s = '{20'hFFFFF, 20'h12345, 20'h10000, 20'h0FFFF, 20'd4, 20'd5, 20'd6, 20'd7, 20'd8};
`ifdef RW_SAT_EN
      e = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
`else
      e = '{16'hFFFF, 16'h2345, 16'h0000, 16'hFFFF, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
`endif
      job_flow(8'h50, s, e);

      // 6: reset mid-job with data still buffered, then a fresh job from 0
      start_job(8'h60);
      ram_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         web_in = 1'b1;
         sum_in = 20'h400 + 20'(k);
         step();
      end
      web_in = 1'b0;
      step();
      chk("mid_three_written", 32'(ram_we), 32'd0);
      ram_ready = 1'b0;
      web_in    = 1'b1;
      sum_in    = 20'h500;
      step();
      sum_in = 20'h501;
      step();
      web_in = 1'b0;
      chk("mid_pending_we", 32'(ram_we), 32'd1);
      chk("mid_pending_addr", 32'(ram_addr), 32'h63);
      rst = 1'b1;
      step();
      chk("mid_rst_we", 32'(ram_we), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_addr", 32'(ram_addr), 32'd0);
      chk("mid_rst_data", 32'(ram_wdata), 32'd0);
      rst = 1'b0;
      step();
      chk("post_rst_we", 32'(ram_we), 32'd0);
      for (int i = 0; i < 9; i++) begin
         s[i] = 20'h600 + 20'(i);
         e[i] = 16'h600 + 16'(i);
      end
      job_flow(8'h00, s, e);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
